input_debouncer: RTL and testbench

- Conditions a raw asynchronous level input, such as a push-button or external strobe, into a clean, clock-synchronous level.
- Also produces single-cycle edge pulses.
- Sits directly upstream of the team's D-type storage flops: dout drives their d input; rise/fall drive toggle/enable logic.
- Rejects glitches and contact bounce shorter than DEBOUNCE_CYCLES clocks.

---
 rtl/input_debouncer.sv | 147 ++++++++++++++
 tb/tb_input_debouncer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous level: synchronizer chain, stability counter and a
// four-state qualifier FSM. Define DEBOUNCE_TOGGLE_EN to build the press-to-toggle register.
module input_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy,
  output logic toggle_q
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_WIDTH) - 1) begin : gen_bad_cycles
    $error("DEBOUNCE_CYCLES must be in 2..2**CNT_WIDTH-1");
  end

  typedef enum logic [1:0] {
    StStableLo = 2'd0,
    StWaitHi   = 2'd1,
    StStableHi = 2'd2,
    StWaitLo   = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // din is touched only by the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StStableLo;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StStableLo: begin
        if (s) begin
          state_d = StWaitHi;
          cnt_d   = CNT_WIDTH'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StWaitHi: begin
        if (!s) begin
          state_d = StStableLo;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableHi;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StStableHi: begin
        if (!s) begin
          state_d = StWaitLo;
          cnt_d   = CNT_WIDTH'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StWaitLo: begin
        if (s) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableLo;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = StStableLo;
        cnt_d   = '0;
      end
    endcase
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == StWaitHi) || (state_q == StWaitLo);

`ifdef DEBOUNCE_TOGGLE_EN
  logic toggle_state;

  // Flips on the edge after rise is registered, so it trails the rise pulse by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_state <= 1'b0;
    end else begin
      toggle_state <= toggle_state ^ rise_q;
    end
  end

  assign toggle_q = toggle_state;
`else
  assign toggle_q = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: the driver pushes the expected outputs after every
// posedge, a separate monitor pops and compares them on the following negedge.
module tb_input_debouncer;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned CntWidth   = 16;
  localparam int unsigned Cycles     = 4;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout, rise, fall, busy, toggle_q;

  input_debouncer #(
    .SYNC_STAGES    (SyncStages),
    .CNT_WIDTH      (CntWidth),
    .DEBOUNCE_CYCLES(Cycles)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy),
    .toggle_q(toggle_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic dout;
    logic rise;
    logic fall;
    logic busy;
    logic toggle;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model: dout flips once s has disagreed with it for Cycles consecutive
  // samples, where s is din delayed by SyncStages clock edges.
  bit   line[$];
  int   run;
  exp_t m;

  function automatic void model_clear();
    line.delete();
    for (int i = 0; i < int'(SyncStages); i++) line.push_back(1'b0);
    run = 0;
    m   = '0;
  endfunction

  function automatic void model_edge(input bit d);
    bit s;
    s = line.pop_front();
    line.push_back(d);
`ifdef DEBOUNCE_TOGGLE_EN
    m.toggle = m.toggle ^ m.rise;
`else
    m.toggle = 1'b0;
`endif
    m.rise = 1'b0;
    m.fall = 1'b0;
    if (s != m.dout) begin
      run++;
      if (run == int'(Cycles)) begin
        m.dout = s;
        m.rise = s;
        m.fall = !s;
        run    = 0;
      end
    end else begin
      run = 0;
    end
    m.busy = (run != 0);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dout", dout, e.dout);
        check("rise", rise, e.rise);
        check("fall", fall, e.fall);
        check("busy", busy, e.busy);
        check("toggle_q", toggle_q, e.toggle);
        check("rise_fall_exclusive", rise & fall, 1'b0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    if (rst) model_clear();
    else model_edge(din);
    exp_q.push_back(m);
    #1;
  endtask

  task automatic hold(input bit v, input int n);
    din = v;
    repeat (n) step();
  endtask

  // Asserts rst mid-cycle; the pending expectation is replaced by the cleared state.
  task automatic async_reset(input int n);
    #1;
    rst = 1'b1;
    model_clear();
    exp_q.delete();
    exp_q.push_back(m);
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b1;
    model_clear();
    // Reset held with din=1, then release: qualified as a normal rise.
    repeat (3) step();
    rst = 1'b0;
    hold(1'b1, 10);
    // Back to low, then a 3-cycle glitch.
    hold(1'b0, 10);
    hold(1'b1, 3);
    hold(1'b0, 10);
    // Rise then fall.
    hold(1'b1, 10);
    hold(1'b0, 10);
    // Bounce for 10 cycles, then settle high.
    for (int i = 0; i < 10; i++) hold(i[0] ? 1'b0 : 1'b1, 1);
    hold(1'b1, 10);
    hold(1'b0, 10);
    // Reset while qualifying a rise.
    din = 1'b1;
    repeat (SyncStages + 2) step();
    async_reset(2);
    hold(1'b1, 10);
    hold(1'b0, 10);
    // Three clean presses for the toggle register.
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 9);
      hold(1'b0, 9);
    end
    // Random hold lengths around the qualification window, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) async_reset(int'($urandom_range(1, 3)));
      else hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 2 * Cycles + 2)));
    end
    hold(1'b0, 10);
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
